scoreboard_interlock: RTL

//  Parametrised RAW/WAW interlock for the RV32I pipeline, built on a per-register pending-write scoreboard.

---
 rtl/scoreboard_interlock.sv | 134 +++++++++++++
 1 files changed

// File: rtl/scoreboard_interlock.sv
// Per-register pending-write scoreboard that raises a RAW/WAW stall for the instruction in IF/ID.
// Optional write-through bypass of the retiring register is enabled by defining WB_BYPASS_EN.
module scoreboard_interlock #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2,
  parameter int PERF_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_id_valid,
  input  logic [6:0]            if_id_opcode,
  input  logic [REG_ADDR_W-1:0] if_id_read_reg1,
  input  logic [REG_ADDR_W-1:0] if_id_read_reg2,
  input  logic [REG_ADDR_W-1:0] if_id_write_reg,
  input  logic                  if_id_regWrite,
  input  logic                  wb_regWrite,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic                  flush,
  output logic                  stall,
  output logic                  busy,
  output logic [PERF_W-1:0]     perf_stall_cnt,
  output logic                  err_underflow
);

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [CNT_W-1:0]    cnt_rs1, cnt_rs2, cnt_rd;
  logic                rd1_en, rd2_en;
  logic                byp1, byp2, waw_relax;
  logic                issue;
  logic [NUM_REGS-1:0] inc, dec;
  logic                underflow_hit;

  // Source-read enables decoded from the opcode
  always_comb begin
    rd1_en = 1'b0;
    rd2_en = 1'b0;
    case (if_id_opcode)
      OP_R_TYPE, OP_STORE, OP_BRANCH: begin
        rd1_en = 1'b1;
        rd2_en = 1'b1;
      end
      OP_I_TYPE, OP_LOAD, OP_JALR: rd1_en = 1'b1;
      default: begin
        rd1_en = 1'b0;
        rd2_en = 1'b0;
      end
    endcase
  end

  // Look up counts; x0 and out-of-range indices match no entry and read as zero
  always_comb begin
    cnt_rs1 = CNT_ZERO;
    cnt_rs2 = CNT_ZERO;
    cnt_rd  = CNT_ZERO;
    for (int i = 1; i < NUM_REGS; i++) begin
      cnt_rs1 = (if_id_read_reg1 == REG_ADDR_W'(i)) ? cnt[i] : cnt_rs1;
      cnt_rs2 = (if_id_read_reg2 == REG_ADDR_W'(i)) ? cnt[i] : cnt_rs2;
      cnt_rd  = (if_id_write_reg == REG_ADDR_W'(i)) ? cnt[i] : cnt_rd;
    end
  end

  // Write-through relaxation for the register retiring this cycle
  always_comb begin
`ifdef WB_BYPASS_EN
    byp1      = wb_regWrite && (wb_write_reg == if_id_read_reg1) && (cnt_rs1 == CNT_ONE);
    byp2      = wb_regWrite && (wb_write_reg == if_id_read_reg2) && (cnt_rs2 == CNT_ONE);
    waw_relax = wb_regWrite && (wb_write_reg == if_id_write_reg);
`else
    byp1      = 1'b0;
    byp2      = 1'b0;
    waw_relax = 1'b0;
`endif
  end

  // Hazard detection and per-register issue/retire strobes
  always_comb begin
    stall = if_id_valid && (
              (rd1_en && (cnt_rs1 != CNT_ZERO) && !byp1) ||
              (rd2_en && (cnt_rs2 != CNT_ZERO) && !byp2) ||
              (if_id_regWrite && (cnt_rd == CNT_MAX) && !waw_relax));
    issue = if_id_valid && !stall && if_id_regWrite;
    inc           = {NUM_REGS{1'b0}};
    dec           = {NUM_REGS{1'b0}};
    underflow_hit = 1'b0;
    busy          = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc[i] = issue && (if_id_write_reg == REG_ADDR_W'(i));
      dec[i] = wb_regWrite && (wb_write_reg == REG_ADDR_W'(i));
      underflow_hit = underflow_hit || (dec[i] && !inc[i] && (cnt[i] == CNT_ZERO));
      busy = busy || (cnt[i] != CNT_ZERO);
    end
    underflow_hit = underflow_hit && !flush;
  end

  // Pending counters; a matched issue/retire pair leaves the count unchanged
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= CNT_ZERO;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= CNT_ZERO;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec[i] && !inc[i] && (cnt[i] != CNT_ZERO)) cnt[i] <= cnt[i] - CNT_ONE;
        else cnt[i] <= cnt[i];
      end
    end
  end

  // Saturating stall counter and sticky underflow flag survive flush
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cnt <= {PERF_W{1'b0}};
      err_underflow  <= 1'b0;
    end else begin
      if (stall && (perf_stall_cnt != PERF_MAX)) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (underflow_hit) err_underflow <= 1'b1;
    end
  end

endmodule
